// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: buffers the two previous rows of a raster pixel
// stream and emits one valid-only neighbourhood per interior pixel.
module conv_window_gen #(
    parameter int XB    = 10,
    parameter int YB    = 10,
    parameter int PB    = 8,
    parameter int MAX_W = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic [PB-1:0]   px_in_data,
    input  logic            px_in_valid,
    output logic            px_in_ready,
    output logic [9*PB-1:0] win_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            win_last_x,
    output logic            win_last_y,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XB-1:0]   x_q, x_d;
    logic [YB-1:0]   y_q, y_d;
    logic [XB-1:0]   cfg_w_q, cfg_w_d;
    logic [YB-1:0]   cfg_h_q, cfg_h_d;
    logic [9*PB-1:0] sh_q, sh_d;
    logic [9*PB-1:0] win_data_q, win_data_d;
    logic            win_valid_q, win_valid_d;
    logic            win_last_x_q, win_last_x_d;
    logic            win_last_y_q, win_last_y_d;
    logic            done_q, done_d;

    logic [PB-1:0]   lb0_q [MAX_W];
    logic [PB-1:0]   lb1_q [MAX_W];

    logic [XB-1:0]   w_eff_s;
    logic [YB-1:0]   h_eff_s;
    logic            ready_s;
    logic            acc_s;
    logic            end_x_s;
    logic            end_y_s;
    logic            emit_s;
    logic [9*PB-1:0] win_upd_s;

    // Handshake, effective frame size and position decode.
    // The first pixel of a frame is accepted while the shadow cfg is still
    // tracking the ports, so decisions in IDLE use the port values directly.
    // A width/height of 0 wraps to 2**XB / 2**YB through modular arithmetic.
    always_comb begin
        ready_s = !rst && (state_q != DRAIN) && (!win_valid_q || win_ready);
        acc_s   = px_in_valid && ready_s;
        if (state_q == IDLE) begin
            w_eff_s = cfg_width;
            h_eff_s = cfg_height;
        end else begin
            w_eff_s = cfg_w_q;
            h_eff_s = cfg_h_q;
        end
        end_x_s = (x_q == (w_eff_s - XB'(1)));
        end_y_s = (y_q == (h_eff_s - YB'(1)));
        emit_s  = acc_s && (x_q >= XB'(2)) && (y_q >= YB'(2));
    end

    // Window shifted left by one column with the new column {lb1, lb0, pixel}.
    always_comb begin
        win_upd_s = '0;
        for (int r = 0; r < 3; r++) begin
            win_upd_s[PB*(3*r)   +: PB] = sh_q[PB*(3*r+1) +: PB];
            win_upd_s[PB*(3*r+1) +: PB] = sh_q[PB*(3*r+2) +: PB];
        end
        win_upd_s[PB*2 +: PB] = lb1_q[x_q];
        win_upd_s[PB*5 +: PB] = lb0_q[x_q];
        win_upd_s[PB*8 +: PB] = px_in_data;
    end

    // Next-state logic for the FSM, position counters and output register.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        sh_d         = sh_q;
        win_data_d   = win_data_q;
        win_valid_d  = win_valid_q;
        win_last_x_d = win_last_x_q;
        win_last_y_d = win_last_y_q;
        done_d       = 1'b0;

        if (state_q == IDLE) begin
            cfg_w_d = cfg_width;
            cfg_h_d = cfg_height;
        end else begin
            cfg_w_d = cfg_w_q;
            cfg_h_d = cfg_h_q;
        end

        if (acc_s) begin
            sh_d = win_upd_s;
            if (end_x_s) begin
                x_d = '0;
                if (end_y_s) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + YB'(1);
                end
            end else begin
                x_d = x_q + XB'(1);
                y_d = y_q;
            end
        end else begin
            sh_d = sh_q;
        end

        case (state_q)
            IDLE: begin
                if (acc_s) begin
                    state_d = (end_x_s && end_y_s) ? DRAIN : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (acc_s && end_x_s && end_y_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!win_valid_q || win_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (emit_s) begin
            win_valid_d  = 1'b1;
            win_data_d   = win_upd_s;
            win_last_x_d = end_x_s;
            win_last_y_d = end_y_s;
        end else if (win_ready) begin
            win_valid_d  = 1'b0;
        end else begin
            win_valid_d  = win_valid_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            sh_q         <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            win_last_x_q <= 1'b0;
            win_last_y_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cfg_w_q      <= cfg_w_d;
            cfg_h_q      <= cfg_h_d;
            sh_q         <= sh_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            win_last_x_q <= win_last_x_d;
            win_last_y_q <= win_last_y_d;
            done_q       <= done_d;
        end
    end

    // Line memories: every row is written before it is read, so no reset.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            lb1_q[x_q] <= lb0_q[x_q];
            lb0_q[x_q] <= px_in_data;
        end
    end

    assign px_in_ready = ready_s;
    assign win_data    = win_data_q;
    assign win_valid   = win_valid_q;
    assign win_last_x  = win_last_x_q;
    assign win_last_y  = win_last_y_q;
    assign done        = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: windows are predicted from whole-frame
// pixel arrays and matched in order on every output handshake.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cfg_width;
    logic [9:0]  cfg_height;
    logic [7:0]  px_in_data;
    logic        px_in_valid;
    logic        px_in_ready;
    logic [71:0] win_data;
    logic        win_valid;
    logic        win_ready = 1'b1;
    logic        win_last_x;
    logic        win_last_y;
    logic        done;

    conv_window_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .px_in_data (px_in_data),
        .px_in_valid(px_in_valid),
        .px_in_ready(px_in_ready),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_last_x (win_last_x),
        .win_last_y (win_last_y),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] d;
        logic        lx;
        logic        ly;
    } win_t;

    win_t        exp_q[$];
    logic [7:0]  pix [4096];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          nwin = 0;
    int          stall_obs = 0;
    int          ready_mode = 0;
    int          stall_left = 0;
    logic        prev_stall = 1'b0;
    logic        prev_done = 1'b0;
    logic [71:0] held_data = '0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every interior pixel (x,y) yields the 3x3 block whose
    // bottom-right corner it is, listed in raster order.
    task automatic build_expect(input int w, input int h);
        win_t e;
        for (int y = 2; y < h; y++) begin
            for (int x = 2; x < w; x++) begin
                e.d = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        e.d[8*(3*r+c) +: 8] = pix[(y-2+r)*w + (x-2+c)];
                    end
                end
                e.lx = (x == w-1);
                e.ly = (y == h-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_cfg(input int w, input int h);
        cfg_width  = w[9:0];
        cfg_height = h[9:0];
    endtask

    // Sends pixels 0..n-1 of pix[]; optionally retargets cfg after chg_at accepts.
    task automatic drive_frame(input int n, input int gap_pct, input int chg_at,
                               input int chg_w, input int chg_h);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < n && guard < n*10 + 200) begin
            px_in_valid = ($urandom_range(99) >= gap_pct);
            px_in_data  = pix[i];
            @(negedge clk);
            acc = px_in_valid && px_in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            if (i == chg_at) set_cfg(chg_w, chg_h);
            guard++;
        end
        px_in_valid = 1'b0;
        check_eq("pixels_sent", 72'(i), 72'(n));
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", 72'(done_cnt), 72'(target));
        repeat (3) @(negedge clk);
        check_eq("done_once", 72'(done_cnt), 72'(target));
        check_eq("queue_empty", 72'(exp_q.size()), 72'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: win_ready = ($urandom_range(3) != 0);
            3: begin
                if (win_valid && stall_left > 0) begin
                    win_ready = 1'b0;
                    stall_left--;
                end else begin
                    win_ready = 1'b1;
                end
            end
            default: win_ready = 1'b1;
        endcase
    end

    // Output monitor: in-order window match, stall stability and done pulse width.
    always @(negedge clk) begin
        win_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", win_valid, 1'b1);
                check_eq("hold_data", win_data, held_data);
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_window", 72'(exp_q.size()), 72'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("win_data", win_data, e.d);
                    check_eq("win_last_x", win_last_x, e.lx);
                    check_eq("win_last_y", win_last_y, e.ly);
                end
                nwin++;
            end
            prev_stall = win_valid && !win_ready;
            held_data  = win_data;
            if (prev_stall) begin
                stall_obs++;
                check_eq("stall_ready", px_in_ready, 1'b0);
            end
            if (done) begin
                check_eq("done_width", prev_done, 1'b0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    initial begin
        int n0;
        int w;
        int h;
        rst         = 1'b1;
        px_in_valid = 1'b0;
        px_in_data  = 8'd0;
        set_cfg(4, 4);
        repeat (2) @(negedge clk);
        check_eq("rst_ready", px_in_ready, 1'b0);
        check_eq("rst_valid", win_valid, 1'b0);
        check_eq("rst_data", win_data, 72'd0);
        check_eq("rst_flags", {win_last_x, win_last_y, done}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4x4 ramp with exact done timing.
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        build_expect(4, 4);
        n0 = nwin;
        drive_frame(16, 0, -1, 0, 0);
        @(negedge clk);
        check_eq("done_early", done, 1'b0);
        @(negedge clk);
        check_eq("done_at2", done, 1'b1);
        wait_done(1);
        check_eq("t1_count", 72'(nwin - n0), 72'd4);

        // Same frame with five stalled cycles on the first window.
        build_expect(4, 4);
        stall_obs  = 0;
        stall_left = 5;
        ready_mode = 3;
        n0 = nwin;
        drive_frame(16, 0, -1, 0, 0);
        wait_done(2);
        check_eq("t2_stalls", 72'(stall_obs), 72'd5);
        check_eq("t2_count", 72'(nwin - n0), 72'd4);
        ready_mode = 0;

        // 3x3 single window.
        set_cfg(3, 3);
        for (int i = 0; i < 9; i++) pix[i] = 8'(i + 1);
        build_expect(3, 3);
        n0 = nwin;
        drive_frame(9, 0, -1, 0, 0);
        wait_done(3);
        check_eq("t3_count", 72'(nwin - n0), 72'd1);

        // 5x4 frame with cfg moved to 8x8 mid-frame, then an 8x8 frame.
        set_cfg(5, 4);
        for (int i = 0; i < 20; i++) pix[i] = 8'(i);
        build_expect(5, 4);
        n0 = nwin;
        drive_frame(20, 20, 7, 8, 8);
        wait_done(4);
        check_eq("t4a_count", 72'(nwin - n0), 72'd6);
        for (int i = 0; i < 64; i++) pix[i] = 8'(100 + i);
        build_expect(8, 8);
        n0 = nwin;
        drive_frame(64, 20, -1, 0, 0);
        wait_done(5);
        check_eq("t4b_count", 72'(nwin - n0), 72'd36);

        // Reset inside row 2, then replay the 4x4 ramp.
        set_cfg(4, 4);
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        drive_frame(9, 0, -1, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ready", px_in_ready, 1'b0);
        check_eq("mid_rst_outs", {win_valid, win_last_x, win_last_y, done}, 4'b0000);
        check_eq("mid_rst_data", win_data, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        build_expect(4, 4);
        n0 = nwin;
        drive_frame(16, 0, -1, 0, 0);
        wait_done(6);
        check_eq("t5_count", 72'(nwin - n0), 72'd4);

        // Full-width 1024x3 frame, random pixels, gaps and backpressure.
        ready_mode = 1;
        set_cfg(1024, 3);
        for (int i = 0; i < 3072; i++) pix[i] = 8'($urandom_range(255));
        build_expect(1024, 3);
        n0 = nwin;
        drive_frame(3072, 20, -1, 0, 0);
        wait_done(7);
        check_eq("t6_count", 72'(nwin - n0), 72'd1022);

        // Random small frames, including degenerate sizes.
        for (int f = 0; f < 6; f++) begin
            w = $urandom_range(12, 1);
            h = $urandom_range(6, 1);
            set_cfg(w, h);
            for (int i = 0; i < w*h; i++) pix[i] = 8'($urandom_range(255));
            build_expect(w, h);
            n0 = nwin;
            drive_frame(w*h, 30, -1, 0, 0);
            wait_done(8 + f);
            check_eq("rnd_count", 72'(nwin - n0),
                     72'(((w > 2) && (h > 2)) ? (w-2)*(h-2) : 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
